// File: rtl/control_sequencer.sv
// Instruction control sequencer: valid/ready issue, opcode/mode decode and a micro-cycle counter
// whose length depends on the MOV addressing mode. Optional CTRL_TRAP_EN traps illegal opcodes.
`ifndef MOV
`define MOV 5'd2
`endif

module control_sequencer #(
  parameter int unsigned      INSTR_W = 16,
  parameter int unsigned      OPC_W   = 5,
  parameter int unsigned      ADDRM_W = 3,
  parameter int unsigned      CYC_W   = 4,
  parameter int unsigned      MAX_CYC = 7,
  parameter logic [OPC_W-1:0] MOV_OPC = `MOV,
  parameter int unsigned      NUM_OPC = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               stall,
  input  logic               flush,
  output logic               state,
  output logic [CYC_W-1:0]   cycle,
  output logic [ADDRM_W-1:0] ADDRM,
  output logic [OPC_W-1:0]   opcode,
  output logic               done,
  output logic               trap
);

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  localparam logic [CYC_W-1:0]   LastMax = CYC_W'(MAX_CYC);
  localparam logic [ADDRM_W-1:0] ModeImm = ADDRM_W'(1);
  localparam logic [ADDRM_W-1:0] ModeReg = ADDRM_W'(2);
  localparam logic [ADDRM_W-1:0] ModeDir = ADDRM_W'(3);

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cycle_q, cycle_d;
  logic [CYC_W-1:0]   last_q, last_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [ADDRM_W-1:0] addrm_q, addrm_d;
  logic               done_q, done_d;
  logic               trap_q, trap_d;

  logic [OPC_W-1:0]   instr_opc;
  logic [ADDRM_W-1:0] instr_mode;
  logic [ADDRM_W-1:0] instr_addrm;
  logic [CYC_W-1:0]   instr_last;
  logic               instr_illegal;
  logic               at_last;
  logic               ready;
  logic               accept;
  logic               unused_instr_lo;

  assign instr_opc       = instr[INSTR_W-1 -: OPC_W];
  assign instr_mode      = instr[INSTR_W-OPC_W-1 -: ADDRM_W];
  assign unused_instr_lo = ^instr[INSTR_W-OPC_W-ADDRM_W-1:0];

`ifdef CTRL_TRAP_EN
  assign instr_illegal = (32'(instr_opc) >= NUM_OPC);
`else
  logic unused_cfg;
  assign instr_illegal = 1'b0;
  assign unused_cfg    = (NUM_OPC == 0);
`endif

  // Decode of the incoming word, consumed only on the accepting edge.
  always_comb begin
    instr_last  = LastMax;
    instr_addrm = '0;
    if (instr_opc == MOV_OPC) begin
      instr_addrm = instr_mode;
      if (instr_mode == ModeImm) begin
        instr_last = CYC_W'(3);
      end else if (instr_mode == ModeReg) begin
        instr_last = CYC_W'(2);
      end else if (instr_mode == ModeDir) begin
        instr_last = CYC_W'(5);
      end
    end
  end

  assign at_last = (cycle_q == last_q);
  assign ready   = (state_q == StIdle) || (at_last && !stall && !flush);
  assign accept  = instr_valid && ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cycle_q <= '0;
      last_q  <= LastMax;
      opc_q   <= '0;
      addrm_q <= '0;
      done_q  <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      last_q  <= last_d;
      opc_q   <= opc_d;
      addrm_q <= addrm_d;
      done_q  <= done_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    last_d  = last_q;
    opc_d   = opc_q;
    addrm_d = addrm_q;
    done_d  = 1'b0;
    trap_d  = 1'b0;

    if (state_q == StExec && flush) begin
      state_d = StIdle;
      cycle_d = '0;
    end else if (state_q == StExec && stall) begin
      state_d = state_q;
    end else if (state_q == StExec && !at_last) begin
      cycle_d = cycle_q + CYC_W'(1);
    end else begin
      // Idle, or the last cycle of EXEC retiring; a new instruction may issue with no bubble.
      if (state_q == StExec) begin
        done_d  = 1'b1;
        state_d = StIdle;
        cycle_d = '0;
      end
      if (accept) begin
        opc_d   = instr_opc;
        cycle_d = '0;
        if (instr_illegal) begin
          addrm_d = '0;
          trap_d  = 1'b1;
          state_d = StIdle;
        end else begin
          addrm_d = instr_addrm;
          last_d  = instr_last;
          state_d = StExec;
        end
      end
    end
  end

  always_comb begin
    instr_ready = ready;
    state       = (state_q == StExec);
    cycle       = cycle_q;
    ADDRM       = addrm_q;
    opcode      = opc_q;
    done        = done_q;
    trap        = trap_q;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_control_sequencer;

  localparam logic [4:0] TbMov = 5'd2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        instr_ready;
  logic        state;
  logic [3:0]  cycle;
  logic [2:0]  ADDRM;
  logic [4:0]  opcode;
  logic        done;
  logic        trap;

  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] obs;
  assign obs = {state, cycle, done, instr_ready};

  control_sequencer #(
    .INSTR_W(16), .OPC_W(5), .ADDRM_W(3), .CYC_W(4), .MAX_CYC(7), .MOV_OPC(TbMov), .NUM_OPC(24)
  ) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stall(stall), .flush(flush), .state(state), .cycle(cycle),
    .ADDRM(ADDRM), .opcode(opcode), .done(done), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [4:0] opc, input logic [2:0] mode);
    logic [7:0] lo;
    lo = 8'($urandom);
    return {opc, mode, lo};
  endfunction

  function automatic logic [6:0] ex(input bit st, input int cyc, input bit dn, input bit rdy);
    return {st, 4'(cyc), dn, rdy};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if (obs !== ex(0, 0, 0, 1) || trap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_assert: obs=%b trap=%b, want obs=%b trap=0", obs, trap, ex(0, 0, 0, 1));
    end
    #9;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({obs, opcode, ADDRM, trap} !== {ex(0, 0, 0, 1), 5'd0, 3'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: obs=%b opc=%0d addrm=%0d trap=%b, want obs=%b zeros",
                 i, obs, opcode, ADDRM, trap, ex(0, 0, 0, 1));
      end
    end
  endtask

  task automatic test_mov_imm();
    instr = mk(TbMov, 3'b001);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (obs !== ex(1, k, 0, k == 3) || ADDRM !== 3'b001 || opcode !== TbMov) begin
        n_fail++;
        $display("FAIL mov_imm_cyc%0d: obs=%b addrm=%0d opc=%0d, want obs=%b addrm=1 opc=%0d",
                 k, obs, ADDRM, opcode, ex(1, k, 0, k == 3), TbMov);
      end
    end
    tick();
    n_checks++;
    if (obs !== ex(0, 0, 1, 1)) begin
      n_fail++;
      $display("FAIL mov_imm_done: obs=%b, want %b", obs, ex(0, 0, 1, 1));
    end
    tick();
    n_checks++;
    if (obs !== ex(0, 0, 0, 1) || ADDRM !== 3'b001) begin
      n_fail++;
      $display("FAIL mov_imm_idle: obs=%b addrm=%0d, want %b addrm=1", obs, ADDRM, ex(0, 0, 0, 1));
    end
  endtask

  task automatic test_non_mov();
    instr = mk(5'd3, 3'b011);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (obs !== ex(1, k, 0, k == 7) || ADDRM !== 3'd0 || opcode !== 5'd3) begin
        n_fail++;
        $display("FAIL non_mov_cyc%0d: obs=%b addrm=%0d opc=%0d, want obs=%b addrm=0 opc=3",
                 k, obs, ADDRM, opcode, ex(1, k, 0, k == 7));
      end
    end
    tick();
    n_checks++;
    if (obs !== ex(0, 0, 1, 1)) begin
      n_fail++;
      $display("FAIL non_mov_done: obs=%b, want %b", obs, ex(0, 0, 1, 1));
    end
  endtask

  task automatic test_back_to_back();
    instr = mk(TbMov, 3'b010);
    instr_valid = 1'b1;
    tick();
    instr = mk(TbMov, 3'b011);
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (obs !== ex(1, k, 0, k == 2) || ADDRM !== 3'b010) begin
        n_fail++;
        $display("FAIL b2b_first_cyc%0d: obs=%b addrm=%0d, want obs=%b addrm=2",
                 k, obs, ADDRM, ex(1, k, 0, k == 2));
      end
    end
    tick();
    instr_valid = 1'b0;
    n_checks++;
    if (obs !== ex(1, 0, 1, 0) || ADDRM !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b_handover: obs=%b addrm=%0d, want obs=%b addrm=3",
               obs, ADDRM, ex(1, 0, 1, 0));
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (obs !== ex(1, k, 0, k == 5)) begin
        n_fail++;
        $display("FAIL b2b_second_cyc%0d: obs=%b, want %b", k, obs, ex(1, k, 0, k == 5));
      end
    end
    tick();
    n_checks++;
    if (obs !== ex(0, 0, 1, 1)) begin
      n_fail++;
      $display("FAIL b2b_done: obs=%b, want %b", obs, ex(0, 0, 1, 1));
    end
  endtask

  task automatic test_stall_flush_reset();
    instr = mk(TbMov, 3'b011);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    stall = 1'b1;
    #1;
    n_checks++;
    if (obs !== ex(1, 2, 0, 0)) begin
      n_fail++;
      $display("FAIL stall_entry: obs=%b, want %b", obs, ex(1, 2, 0, 0));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== ex(1, 2, 0, 0) || ADDRM !== 3'b011) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: obs=%b addrm=%0d, want %b addrm=3",
                 i, obs, ADDRM, ex(1, 2, 0, 0));
      end
    end
    stall = 1'b0;
    tick();
    tick();
    // Offer a competing instruction during flush; it must be refused.
    flush = 1'b1;
    instr = mk(5'd9, 3'b001);
    instr_valid = 1'b1;
    #1;
    n_checks++;
    if (obs !== ex(1, 4, 0, 0)) begin
      n_fail++;
      $display("FAIL flush_ready: obs=%b, want %b", obs, ex(1, 4, 0, 0));
    end
    tick();
    flush = 1'b0;
    instr_valid = 1'b0;
    n_checks++;
    if (obs !== ex(0, 0, 0, 1) || opcode !== TbMov) begin
      n_fail++;
      $display("FAIL flush_idle: obs=%b opc=%0d, want %b opc=%0d", obs, opcode,
               ex(0, 0, 0, 1), TbMov);
    end
    instr = mk(TbMov, 3'b011);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({obs, opcode, ADDRM, trap} !== {ex(0, 0, 0, 1), 5'd0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: obs=%b opc=%0d addrm=%0d trap=%b, want obs=%b zeros",
               obs, opcode, ADDRM, trap, ex(0, 0, 0, 1));
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_illegal_opcode();
    instr = mk(5'd30, 3'b001);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
`ifdef CTRL_TRAP_EN
    n_checks++;
    if ({obs, trap, opcode, ADDRM} !== {ex(0, 0, 0, 1), 1'b1, 5'd30, 3'd0}) begin
      n_fail++;
      $display("FAIL trap_pulse: obs=%b trap=%b opc=%0d addrm=%0d, want obs=%b trap=1 opc=30",
               obs, trap, opcode, ADDRM, ex(0, 0, 0, 1));
    end
    tick();
    n_checks++;
    if (trap !== 1'b0 || obs !== ex(0, 0, 0, 1)) begin
      n_fail++;
      $display("FAIL trap_clear: obs=%b trap=%b, want %b trap=0", obs, trap, ex(0, 0, 0, 1));
    end
`else
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (obs !== ex(1, k, 0, k == 7) || trap !== 1'b0 || opcode !== 5'd30) begin
        n_fail++;
        $display("FAIL opc30_cyc%0d: obs=%b trap=%b opc=%0d, want obs=%b trap=0 opc=30",
                 k, obs, trap, opcode, ex(1, k, 0, k == 7));
      end
    end
    tick();
    n_checks++;
    if (obs !== ex(0, 0, 1, 1)) begin
      n_fail++;
      $display("FAIL opc30_done: obs=%b, want %b", obs, ex(0, 0, 1, 1));
    end
`endif
  endtask

  // Reference: an instruction lasts len(opc,mode)+1 cycles, then done pulses on retirement.
  function automatic int ref_len(input int opc, input int mode);
    if (opc != int'(TbMov)) return 7;
    case (mode)
      1: return 3;
      2: return 2;
      3: return 5;
      default: return 7;
    endcase
  endfunction

  task automatic test_random();
    bit m_exec, m_done, m_trap, m_rdy, acc, ill, v, s, f;
    int m_cyc, m_len, m_opc, m_mode, opc, md;
    logic [19:0] want;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    m_exec = 0; m_done = 0; m_trap = 0; m_cyc = 0; m_len = 7; m_opc = 0; m_mode = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 6);
      s = ($urandom_range(0, 19) < 3);
      f = ($urandom_range(0, 19) == 0);
      opc = $urandom_range(0, 1) ? int'(TbMov) : int'($urandom_range(0, 31));
      md = $urandom_range(0, 7);
      instr = mk(5'(opc), 3'(md));
      instr_valid = v;
      stall = s;
      flush = f;
      #1;
      m_rdy = !m_exec || (m_cyc == m_len && !s && !f);
      n_checks++;
      if (instr_ready !== m_rdy) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: got %b, want %b", i, instr_ready, m_rdy);
      end
      @(posedge clk);
      acc = v && m_rdy;
      m_done = 0;
      m_trap = 0;
      if (m_exec && f) begin
        m_exec = 0;
        m_cyc = 0;
      end else if (m_exec && s) begin
        m_exec = 1;
      end else if (m_exec && m_cyc < m_len) begin
        m_cyc++;
      end else begin
        if (m_exec) begin
          m_done = 1;
          m_exec = 0;
          m_cyc = 0;
        end
        if (acc) begin
`ifdef CTRL_TRAP_EN
          ill = (opc >= 24);
`else
          ill = 0;
`endif
          m_opc = opc;
          m_cyc = 0;
          if (ill) begin
            m_mode = 0;
            m_trap = 1;
          end else begin
            m_exec = 1;
            m_mode = (opc == int'(TbMov)) ? md : 0;
            m_len = ref_len(opc, md);
          end
        end
      end
      #1;
      want = {m_exec, 4'(m_cyc), m_done, m_trap, 5'(m_opc), 3'(m_mode), 5'd0};
      n_checks++;
      if ({state, cycle, done, trap, opcode, ADDRM, 5'd0} !== want) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: st=%b cyc=%0d done=%b trap=%b opc=%0d addrm=%0d, want %h",
                 i, state, cycle, done, trap, opcode, ADDRM, want);
      end
    end
    instr_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_non_mov();
    test_back_to_back();
    test_stall_flush_reset();
    test_illegal_opcode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
